// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: controller states and
// sizing helpers.
package systolic_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } feeder_state_e;

    // Width of the flush counter; it must reach arr_lat + 2*n - 1 cycles.
    function automatic int flush_cnt_w(input int n, input int arr_lat);
        int len;
        len = arr_lat + 2 * n;
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay_line.sv
// Fixed-depth register delay line used for input skew, output deskew and the
// result tag pipe. DEPTH=0 is a plain wire.
module skew_delay_line #(
    parameter int DW    = 32,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][DW-1:0] pipe_q;
            logic [DEPTH-1:0][DW-1:0] pipe_d;

            always_comb begin
                pipe_d    = pipe_q;
                pipe_d[0] = din;
                for (int k = 1; k < DEPTH; k++) begin
                    pipe_d[k] = pipe_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dout = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Feeds a weight-stationary systolic array: latches weights, skews input
// vectors into rows, deskews result columns and tags each result vector.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int DW      = 32,
    parameter int N       = 4,
    parameter int ARR_LAT = 2 * N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [N*N*DW-1:0] w_data,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [N*DW-1:0]   x_data,
    input  logic              x_last,
    output logic              y_valid,
    output logic [N*DW-1:0]   y_data,
    output logic              y_last,
    output logic              batch_done,
    output logic              arr_load_weights,
    output logic              arr_start,
    output logic [N*N*DW-1:0] arr_w,
    output logic [N*DW-1:0]   arr_x,
    input  logic [N*DW-1:0]   arr_y
);

    localparam int FLUSH_LEN = ARR_LAT + 2 * N - 1;
    localparam int CW        = flush_cnt_w(N, ARR_LAT);
    localparam int TAG_DEPTH = ARR_LAT + N - 1;

    feeder_state_e     state_q, state_d;
    logic [N*N*DW-1:0] arr_w_q, arr_w_d;
    logic [N*DW-1:0]   x_skew_q, x_skew_d;
    logic [1:0]        tag_q, tag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N*DW-1:0]   y_aligned;
    logic [1:0]        tag_out;

    always_comb begin
        state_d          = state_q;
        arr_w_d          = arr_w_q;
        x_skew_d         = '0;
        tag_d            = '0;
        cnt_d            = cnt_q;
        w_ready          = 1'b0;
        x_ready          = 1'b0;
        arr_load_weights = 1'b0;
        arr_start        = 1'b0;
        batch_done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    arr_w_d = w_data;
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                arr_load_weights = 1'b1;
                state_d          = ST_STREAM;
            end
            ST_STREAM: begin
                // Cycles without an accepted vector inject a tagless zero bubble.
                x_ready   = 1'b1;
                arr_start = 1'b1;
                if (x_valid) begin
                    x_skew_d = x_data;
                    tag_d    = {1'b1, x_last};
                    if (x_last) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end
                end
            end
            ST_FLUSH: begin
                arr_start = 1'b1;
                if (cnt_q == CW'(FLUSH_LEN - 1)) begin
                    batch_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            arr_w_q  <= '0;
            x_skew_q <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            arr_w_q  <= arr_w_d;
            x_skew_q <= x_skew_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign arr_w = arr_w_q;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            skew_delay_line #(.DW(DW), .DEPTH(g)) u_skew (
                .clk   (clk),
                .reset (reset),
                .din   (x_skew_q[g*DW +: DW]),
                .dout  (arr_x[g*DW +: DW])
            );
            // Column j leaves the array j cycles after column 0.
            skew_delay_line #(.DW(DW), .DEPTH(N - 1 - g)) u_deskew (
                .clk   (clk),
                .reset (reset),
                .din   (arr_y[g*DW +: DW]),
                .dout  (y_aligned[g*DW +: DW])
            );
        end
    endgenerate

    skew_delay_line #(.DW(2), .DEPTH(TAG_DEPTH)) u_tag (
        .clk   (clk),
        .reset (reset),
        .din   (tag_q),
        .dout  (tag_out)
    );

    assign y_valid = tag_out[1];
    assign y_last  = tag_out[1] & tag_out[0];
    assign y_data  = y_valid ? y_aligned : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural weight-stationary
// array attached to the arr_* ports.
module tb_systolic_feeder;

    localparam int DW      = 32;
    localparam int N       = 4;
    localparam int ARR_LAT = 2 * N;
    localparam int HD      = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              w_valid;
    logic              w_ready;
    logic [N*N*DW-1:0] w_data;
    logic              x_valid;
    logic              x_ready;
    logic [N*DW-1:0]   x_data;
    logic              x_last;
    logic              y_valid;
    logic [N*DW-1:0]   y_data;
    logic              y_last;
    logic              batch_done;
    logic              arr_load_weights;
    logic              arr_start;
    logic [N*N*DW-1:0] arr_w;
    logic [N*DW-1:0]   arr_x;
    logic [N*DW-1:0]   arr_y;

    systolic_feeder #(.DW(DW), .N(N), .ARR_LAT(ARR_LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .x_valid          (x_valid),
        .x_ready          (x_ready),
        .x_data           (x_data),
        .x_last           (x_last),
        .y_valid          (y_valid),
        .y_data           (y_data),
        .y_last           (y_last),
        .batch_done       (batch_done),
        .arr_load_weights (arr_load_weights),
        .arr_start        (arr_start),
        .arr_w            (arr_w),
        .arr_x            (arr_x),
        .arr_y            (arr_y)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural array: column j at cycle T sums row i inputs from cycle T-ARR_LAT-j+i.
    logic [N*DW-1:0]   hist [HD];
    logic [N*N*DW-1:0] model_w = '0;
    int                cyc = 0;

    initial begin
        for (int k = 0; k < HD; k++) hist[k] = '0;
        arr_y = '0;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = arr_x;
        if (arr_load_weights) model_w = arr_w;
        for (int j = 0; j < N; j++) begin
            logic [DW-1:0] acc;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            acc = '0;
            for (int i = 0; i < N; i++) begin
                a   = hist[ARR_LAT + j - i][i*DW +: DW];
                b   = model_w[(i*N + j)*DW +: DW];
                acc = acc + a * b;
            end
            arr_y[j*DW +: DW] = acc;
        end
    end

    logic [N*DW-1:0] yq_data [$];
    logic            yq_last [$];
    int              yq_cyc  [$];
    int              done_cnt = 0;
    int              done_cyc = 0;

    always @(negedge clk) begin
        if (y_valid) begin
            yq_data.push_back(y_data);
            yq_last.push_back(y_last);
            yq_cyc.push_back(cyc);
        end
        if (batch_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N*DW-1:0] vec4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [N*N*DW-1:0] mat_ident();
        logic [N*N*DW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N + i)*DW +: DW] = 1;
        return m;
    endfunction

    function automatic logic [N*N*DW-1:0] mat_fill(input logic [DW-1:0] v);
        logic [N*N*DW-1:0] m;
        for (int i = 0; i < N*N; i++) m[i*DW +: DW] = v;
        return m;
    endfunction

    task automatic load_w(input logic [N*N*DW-1:0] m);
        int k;
        for (k = 0; k < 60 && !w_ready; k++) tick();
        if (!w_ready) chk("w_ready_timeout", 0, 1);
        w_valid = 1'b1;
        w_data  = m;
        tick();
        w_valid = 1'b0;
    endtask

    int acc_cyc;

    task automatic send_x(input logic [N*DW-1:0] v, input logic last);
        int k;
        for (k = 0; k < 60 && !x_ready; k++) tick();
        if (!x_ready) chk("x_ready_timeout", 0, 1);
        x_valid = 1'b1;
        x_data  = v;
        x_last  = last;
        tick();
        acc_cyc = cyc;
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic wait_done();
        int prev;
        prev = done_cnt;
        for (int k = 0; k < 100 && done_cnt == prev; k++) tick();
        chk("batch_done_seen", done_cnt, prev + 1);
        tick();
    endtask

    task automatic clear_q();
        yq_data.delete();
        yq_last.delete();
        yq_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        w_valid = 1'b0;
        w_data  = '0;
        x_valid = 1'b0;
        x_data  = '0;
        x_last  = 1'b0;
        tick(); tick(); tick();

        // Reset values
        chk("rst_w_ready", w_ready, 1);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_last", y_last, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_load_w", arr_load_weights, 0);
        chk("rst_start", arr_start, 0);
        chk("rst_arr_x", arr_x, 0);
        chk("rst_arr_w", arr_w, 0);
        reset = 1'b0;
        tick();

        // Identity weights, single vector
        clear_q();
        load_w(mat_ident());
        chk("loadw_pulse", arr_load_weights, 1);
        chk("loadw_start", arr_start, 0);
        tick();
        chk("loadw_one_cycle", arr_load_weights, 0);
        chk("stream_start", arr_start, 1);
        send_x(vec4(1, 2, 3, 4), 1'b1);
        wait_done();
        chk("t1_count", yq_data.size(), 1);
        if (yq_data.size() == 1) begin
            chk("t1_data", yq_data[0], vec4(1, 2, 3, 4));
            chk("t1_last", yq_last[0], 1);
            chk("t1_y_lat", yq_cyc[0] - acc_cyc, ARR_LAT + N - 1);
        end
        chk("t1_done_lat", done_cyc - acc_cyc, ARR_LAT + 2*N - 2);
        chk("t1_idle_w_ready", w_ready, 1);

        // All-2 weights, back-to-back vectors
        clear_q();
        load_w(mat_fill(2));
        send_x(vec4(1, 1, 1, 1), 1'b0);
        send_x(vec4(3, 0, 0, 0), 1'b1);
        wait_done();
        chk("t2_count", yq_data.size(), 2);
        if (yq_data.size() == 2) begin
            chk("t2_data0", yq_data[0], vec4(8, 8, 8, 8));
            chk("t2_data1", yq_data[1], vec4(6, 6, 6, 6));
            chk("t2_last0", yq_last[0], 0);
            chk("t2_last1", yq_last[1], 1);
            chk("t2_consec", yq_cyc[1] - yq_cyc[0], 1);
        end

        // Gapped input, one vector every 3 cycles
        clear_q();
        load_w(mat_ident());
        for (int k = 1; k <= 5; k++) begin
            send_x(vec4(10*k, 10*k + 1, 10*k + 2, 10*k + 3), k == 5);
            if (k < 5) begin tick(); tick(); end
        end
        wait_done();
        chk("t3_count", yq_data.size(), 5);
        if (yq_data.size() == 5) begin
            for (int k = 0; k < 5; k++)
                chk("t3_order", yq_data[k], vec4(10*(k+1), 10*(k+1) + 1, 10*(k+1) + 2, 10*(k+1) + 3));
            chk("t3_last_first", yq_last[0], 0);
            chk("t3_last_final", yq_last[4], 1);
        end

        // Reset three cycles into STREAM
        clear_q();
        load_w(mat_fill(1));
        tick();
        send_x(vec4(5, 5, 5, 5), 1'b0);
        send_x(vec4(6, 6, 6, 6), 1'b0);
        send_x(vec4(7, 7, 7, 7), 1'b0);
        reset = 1'b1;
        tick();
        chk("t4_w_ready", w_ready, 1);
        chk("t4_x_ready", x_ready, 0);
        chk("t4_y_valid", y_valid, 0);
        chk("t4_y_data", y_data, 0);
        chk("t4_arr_x", arr_x, 0);
        chk("t4_arr_w", arr_w, 0);
        chk("t4_start", arr_start, 0);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        chk("t4_no_result", yq_data.size(), 0);
        chk("t4_no_done", batch_done, 0);
        chk("t4_idle", w_ready, 1);

        // w_valid during STREAM is ignored
        clear_q();
        load_w(mat_ident());
        tick();
        chk("t5_stream_w_ready", w_ready, 0);
        w_valid = 1'b1;
        w_data  = mat_fill(2);
        tick();
        w_valid = 1'b0;
        chk("t5_arr_w_hold", arr_w, mat_ident());
        send_x(vec4(1, 2, 3, 4), 1'b1);
        chk("t5_flush_x_ready", x_ready, 0);
        wait_done();
        chk("t5_count", yq_data.size(), 1);
        if (yq_data.size() == 1) chk("t5_data", yq_data[0], vec4(1, 2, 3, 4));

        // Modular overflow
        clear_q();
        load_w(mat_fill(32'hFFFF_FFFF));
        send_x(vec4(2, 2, 2, 2), 1'b1);
        wait_done();
        chk("t6_count", yq_data.size(), 1);
        if (yq_data.size() == 1)
            chk("t6_data", yq_data[0], vec4(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DW, default 32, meaning element width in bits.
REQ-002 SHALL have parameter N, default 4, meaning array dimension.
REQ-003 SHALL have parameter ARR_LAT, default 2*N, meaning cycles from arr_x column-0 element to arr_y column-0 result.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port w_valid  in  1  weight matrix offered.
REQ-007 SHALL have port w_ready  out  1  weight matrix accepted.
REQ-008 SHALL have port w_data  in  N*N*DW  element (i,j) at bits (i*N+j)*DW.
REQ-009 SHALL have port x_valid  in  1  input vector offered.
REQ-010 SHALL have port x_ready  out  1  input vector accepted.
REQ-011 SHALL have port x_data  in  N*DW  element i at bits i*DW.
REQ-012 SHALL have port x_last  in  1  final vector of batch.
REQ-013 SHALL have port y_valid  out  1  result vector valid, one cycle, no backpressure.
REQ-014 SHALL have port y_data  out  N*DW  result element j at bits j*DW.
REQ-015 SHALL have port y_last  out  1  with y_valid, result of the x_last vector.
REQ-016 SHALL have port batch_done  out  1  one-cycle pulse when flush completes.
REQ-017 SHALL have ports arr_load_weights out 1, arr_start out 1, arr_w out N*N*DW, arr_x out N*DW, arr_y in N*DW, driving the systolic array.

Function
REQ-018 SHALL implement states IDLE, LOAD_W, STREAM, FLUSH.
REQ-019 IDLE: w_ready=1, x_ready=0; w_valid&w_ready latches w_data into arr_w, next LOAD_W.
REQ-020 LOAD_W: arr_load_weights=1 for exactly one cycle, next STREAM.
REQ-021 STREAM: x_ready=1, arr_start=1 every cycle; accepted vector enters skew stage with tag=1, else zero vector with tag=0 (bubble).
REQ-022 STREAM: acceptance with x_last=1 moves to FLUSH next cycle.
REQ-023 FLUSH: x_ready=0, arr_start=1, zeros injected; counter runs ARR_LAT+2*N-1 cycles, then batch_done=1 one cycle, next IDLE.
REQ-024 Input skew: arr_x row i SHALL be the accepted element delayed i cycles (row 0 undelayed, combinational from skew register).
REQ-025 Output deskew: arr_y column j SHALL be delayed N-1-j cycles so all columns of one vector align.
REQ-026 Tag pipe of ARR_LAT+N-1 stages SHALL carry {valid,last}; y_valid/y_last asserted when aligned tag exits.
REQ-027 Bubbles SHALL never produce y_valid; result count SHALL equal accepted vector count.
REQ-028 y_data SHALL equal sum over i of x[i]*W[i][j], modulo 2^DW, when ARR_LAT matches array.
REQ-029 w_valid outside IDLE SHALL be ignored; arr_w SHALL hold during STREAM/FLUSH.
REQ-030 Back-to-back batches: new weights accepted only after batch_done.

Reset
REQ-031 On reset: state IDLE, w_ready=1, x_ready=0, y_valid=0, y_last=0, y_data=0, batch_done=0, arr_load_weights=0, arr_start=0, arr_x=0, arr_w=0.
REQ-032 Reset mid-STREAM/FLUSH SHALL clear skew, deskew, tag pipes and counter; no result emitted after reset.

Structure
REQ-033 Shared package SHALL hold state enum and flush-count width function.
REQ-034 Sub-module skew_delay_line (parameters DW, DEPTH; DEPTH=0 passthrough) SHALL implement skew and deskew lanes.

Verification
REQ-035 N=4, W=identity, single x=[1,2,3,4] last -> one y_valid, y=[1,2,3,4], y_last=1, batch_done after flush.
REQ-036 W all 2, x=[1,1,1,1],[3,0,0,0] back-to-back -> y=[8,8,8,8] then [6,6,6,6], consecutive cycles.
REQ-037 x_valid gaps (1 vector every 3 cycles, 5 vectors) -> exactly 5 y_valid, order preserved.
REQ-038 Reset asserted 3 cycles into STREAM -> all outputs at reset values, no y_valid until new batch.
REQ-039 w_valid pulsed during STREAM with different matrix -> ignored, results use original W.
REQ-040 Overflow: W all 0xFFFFFFFF, x all 2 -> y elements 0xFFFFFFF8.
